high_score_keeper: RTL and testbench



---
 rtl/score_pkg.sv | 13 +
 rtl/Lab2.sv | 29 ++
 rtl/high_score_keeper.sv | 117 +++++++++++
 tb/tb_high_score_keeper.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and constants for the score path.
// Digit layout and high-score FSM states.
package score_pkg;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4;

  typedef enum logic [1:0] {
    PLAYING,
    COMPARE,
    RECORD,
    DONE
  } hs_state_t;
endpackage

// File: rtl/Lab2.sv
// Seven-segment decoder: one 4-bit digit to active-low {g..a}.
// Values above 9 show as hex letters A-F.
module Lab2 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b1111111;
    case (bcd)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/high_score_keeper.sv
// Keeps the session best score, flags new records with a blinking LED,
// and drives the four digit displays with either live or best score.
module high_score_keeper
  import score_pkg::*;
#(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                      clkin,
  input  logic                      reset,
  input  logic                      gameOver,
  input  logic [DIGITS*BCD_W-1:0]   score_bcd,
  input  logic                      show_best,
  output logic [DIGITS*BCD_W-1:0]   best_bcd,
  output logic                      new_record,
  output logic [6:0]                hex01,
  output logic [6:0]                hex02,
  output logic [6:0]                hex03,
  output logic [6:0]                hex04
);
  localparam int SW    = DIGITS * BCD_W;
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  hs_state_t        state_q, state_d;
  logic             go_q, go_d;
  logic [SW-1:0]    cap_q, cap_d;
  logic [SW-1:0]    best_q, best_d;
  logic [SW-1:0]    disp_q, disp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             rise;

  assign rise = gameOver & ~go_q;

  always_comb begin
    state_d = state_q;
    go_d    = gameOver;
    cap_d   = cap_q;
    best_d  = best_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    disp_d  = show_best ? best_q : score_bcd;
    unique case (state_q)
      PLAYING: begin
        if (rise) begin
          cap_d   = score_bcd;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        // Raw unsigned compare; equals decimal order for valid BCD.
        if (cap_q > best_q) begin
          best_d  = cap_q;
          cnt_d   = '0;
          phase_d = 1'b1;
          state_d = RECORD;
        end else begin
          state_d = DONE;
        end
      end
      RECORD: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!gameOver) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          state_d = PLAYING;
        end
      end
      DONE: begin
        if (!gameOver) state_d = PLAYING;
      end
      default: state_d = PLAYING;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q <= PLAYING;
      go_q    <= 1'b0;
      cap_q   <= '0;
      best_q  <= '0;
      disp_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      cap_q   <= cap_d;
      best_q  <= best_d;
      disp_q  <= disp_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign best_bcd   = best_q;
  assign new_record = (state_q == RECORD) & phase_q;

  logic [6:0] seg_w [DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    Lab2 u_dec (
      .bcd (disp_q[i*BCD_W +: BCD_W]),
      .seg (seg_w[i])
    );
  end

  assign hex01 = seg_w[0];
  assign hex02 = seg_w[1];
  assign hex03 = seg_w[2];
  assign hex04 = seg_w[3];
endmodule

// File: tb/tb_high_score_keeper.sv
// Directed bench for high_score_keeper with hand-computed expectations.
module tb_high_score_keeper;
  localparam int BD = 4;

  logic        clkin = 1'b0;
  logic        reset;
  logic        gameOver;
  logic [15:0] score_bcd;
  logic        show_best;
  logic [15:0] best_bcd;
  logic        new_record;
  logic [6:0]  hex01, hex02, hex03, hex04;

  int vectors = 0;
  int errors  = 0;

  always #5 clkin = ~clkin;

  high_score_keeper #(.BLINK_DIV(BD)) dut (
    .clkin      (clkin),
    .reset      (reset),
    .gameOver   (gameOver),
    .score_bcd  (score_bcd),
    .show_best  (show_best),
    .best_bcd   (best_bcd),
    .new_record (new_record),
    .hex01      (hex01),
    .hex02      (hex02),
    .hex03      (hex03),
    .hex04      (hex04)
  );

  function automatic logic [6:0] seg(input logic [3:0] d);
    logic [6:0] t [16];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return t[d];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  // Stimulus helper: full game ending at score s, then gameOver dropped.
  task automatic play(input logic [15:0] s);
    score_bcd = s;
    gameOver  = 1'b1;
    tick(2);
    gameOver  = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; gameOver = 1'b0; score_bcd = 16'h0000; show_best = 1'b0;
    tick(2);
    reset = 1'b0;
    vectors++;
    if (best_bcd !== 16'h0000) begin
      errors++; $display("FAIL reset_best got=%h exp=0000", best_bcd);
    end
    vectors++;
    if (new_record !== 1'b0) begin
      errors++; $display("FAIL reset_nr got=%b exp=0", new_record);
    end
    vectors++;
    if ({hex04, hex03, hex02, hex01} !== {4{seg(4'h0)}}) begin
      errors++; $display("FAIL reset_hex got=%h exp=%h",
        {hex04, hex03, hex02, hex01}, {4{seg(4'h0)}});
    end
  endtask

  task automatic test_first_game();
    score_bcd = 16'h0042;
    gameOver  = 1'b1;
    tick(1);
    vectors++;
    if (best_bcd !== 16'h0000 || new_record !== 1'b0) begin
      errors++; $display("FAIL first_e0 best=%h nr=%b exp=0000/0", best_bcd, new_record);
    end
    tick(1);
    vectors++;
    if (best_bcd !== 16'h0042) begin
      errors++; $display("FAIL first_best got=%h exp=0042", best_bcd);
    end
    vectors++;
    if (new_record !== 1'b1) begin
      errors++; $display("FAIL first_nr got=%b exp=1", new_record);
    end
    tick(BD - 1);
    vectors++;
    if (new_record !== 1'b1) begin
      errors++; $display("FAIL blink_pre got=%b exp=1", new_record);
    end
    tick(1);
    vectors++;
    if (new_record !== 1'b0) begin
      errors++; $display("FAIL blink_off got=%b exp=0", new_record);
    end
    tick(BD);
    vectors++;
    if (new_record !== 1'b1) begin
      errors++; $display("FAIL blink_on got=%b exp=1", new_record);
    end
    gameOver = 1'b0;
    tick(1);
    vectors++;
    if (new_record !== 1'b0) begin
      errors++; $display("FAIL first_exit got=%b exp=0", new_record);
    end
  endtask

  task automatic test_lower_equal();
    logic [15:0] sc [2];
    sc = '{16'h0041, 16'h0042};
    foreach (sc[i]) begin
      score_bcd = sc[i];
      gameOver  = 1'b1;
      tick(2);
      vectors++;
      if (best_bcd !== 16'h0042 || new_record !== 1'b0) begin
        errors++; $display("FAIL lower_eq_%h best=%h nr=%b exp=0042/0",
          sc[i], best_bcd, new_record);
      end
      gameOver = 1'b0;
      tick(1);
    end
  endtask

  task automatic test_digit_weight();
    play(16'h0999);
    score_bcd = 16'h1000;
    gameOver  = 1'b1;
    tick(2);
    vectors++;
    if (best_bcd !== 16'h1000 || new_record !== 1'b1) begin
      errors++; $display("FAIL digit_weight best=%h nr=%b exp=1000/1", best_bcd, new_record);
    end
    gameOver = 1'b0;
    tick(1);
  endtask

  task automatic test_held();
    score_bcd = 16'h2000;
    gameOver  = 1'b1;
    tick(1);
    score_bcd = 16'h9999;
    tick(1);
    vectors++;
    if (best_bcd !== 16'h2000 || new_record !== 1'b1) begin
      errors++; $display("FAIL held_e1 best=%h nr=%b exp=2000/1", best_bcd, new_record);
    end
    tick(98);
    vectors++;
    if (best_bcd !== 16'h2000) begin
      errors++; $display("FAIL held_best got=%h exp=2000", best_bcd);
    end
    gameOver = 1'b0;
    tick(3);
    vectors++;
    if (best_bcd !== 16'h2000 || new_record !== 1'b0) begin
      errors++; $display("FAIL held_after best=%h nr=%b exp=2000/0", best_bcd, new_record);
    end
  endtask

  task automatic test_pulse();
    do_reset();
    play(16'h0042);
    score_bcd = 16'h0050;
    gameOver  = 1'b1;
    tick(1);
    gameOver  = 1'b0;
    tick(1);
    vectors++;
    if (best_bcd !== 16'h0050 || new_record !== 1'b1) begin
      errors++; $display("FAIL pulse_e1 best=%h nr=%b exp=0050/1", best_bcd, new_record);
    end
    tick(1);
    vectors++;
    if (new_record !== 1'b0) begin
      errors++; $display("FAIL pulse_one_cycle got=%b exp=0", new_record);
    end
    tick(2);
    vectors++;
    if (new_record !== 1'b0 || best_bcd !== 16'h0050) begin
      errors++; $display("FAIL pulse_settle best=%h nr=%b exp=0050/0", best_bcd, new_record);
    end
  endtask

  task automatic test_display();
    do_reset();
    play(16'h1234);
    score_bcd = 16'h0007;
    show_best = 1'b0;
    tick(1);
    vectors++;
    if ({hex04, hex03, hex02, hex01} !== {seg(0), seg(0), seg(0), seg(7)}) begin
      errors++; $display("FAIL disp_live got=%h exp=%h",
        {hex04, hex03, hex02, hex01}, {seg(0), seg(0), seg(0), seg(7)});
    end
    show_best = 1'b1;
    #1;
    vectors++;
    if (hex01 !== seg(7)) begin
      errors++; $display("FAIL disp_latency got=%b exp=%b", hex01, seg(7));
    end
    tick(1);
    vectors++;
    if ({hex04, hex03, hex02, hex01} !== {seg(1), seg(2), seg(3), seg(4)}) begin
      errors++; $display("FAIL disp_best got=%h exp=%h",
        {hex04, hex03, hex02, hex01}, {seg(1), seg(2), seg(3), seg(4)});
    end
    show_best = 1'b0;
    tick(1);
    vectors++;
    if ({hex04, hex03, hex02, hex01} !== {seg(0), seg(0), seg(0), seg(7)}) begin
      errors++; $display("FAIL disp_back got=%h exp=%h",
        {hex04, hex03, hex02, hex01}, {seg(0), seg(0), seg(0), seg(7)});
    end
  endtask

  task automatic test_reset_collision();
    reset     = 1'b1;
    score_bcd = 16'h5555;
    gameOver  = 1'b1;
    tick(1);
    reset    = 1'b0;
    gameOver = 1'b0;
    vectors++;
    if (best_bcd !== 16'h0000 || new_record !== 1'b0) begin
      errors++; $display("FAIL rst_rise best=%h nr=%b exp=0000/0", best_bcd, new_record);
    end
    tick(3);
    vectors++;
    if (best_bcd !== 16'h0000 || new_record !== 1'b0) begin
      errors++; $display("FAIL rst_rise_later best=%h nr=%b exp=0000/0", best_bcd, new_record);
    end
    score_bcd = 16'h0100;
    gameOver  = 1'b1;
    tick(2);
    vectors++;
    if (best_bcd !== 16'h0100 || new_record !== 1'b1) begin
      errors++; $display("FAIL rst_rec_setup best=%h nr=%b exp=0100/1", best_bcd, new_record);
    end
    reset = 1'b1;
    tick(1);
    vectors++;
    if (best_bcd !== 16'h0000 || new_record !== 1'b0) begin
      errors++; $display("FAIL rst_in_record best=%h nr=%b exp=0000/0", best_bcd, new_record);
    end
    reset    = 1'b0;
    gameOver = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_first_game();
    test_lower_equal();
    test_digit_weight();
    test_held();
    test_pulse();
    test_display();
    test_reset_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
